dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 97 +++++++++
 tb/tb_dm_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin memory arbiter with a bounded lock for port 1.
// Each access runs IDLE -> ACCESS -> RESP and pulses the grant and done signals of the winner.
module dm_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    output logic          gnt0_o,
    output logic          done0_o,
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic          lock1_i,
    output logic          gnt1_o,
    output logic          done1_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_din_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_dout_i,
    output logic          busy_o
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t        state_q, state_d;
    logic          win_q, win_d, last_q, last_d, we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d, rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_act, pick;
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        // A non-zero count means the previous grant was a locked port-1 grant.
        lock_act = (cnt_q != '0) && (cnt_q < CW'(MAX_LOCK));
        pick     = req1_i & (~req0_i | lock_act | ~last_q);
        case (state_q)
            IDLE: if (req0_i | req1_i) begin
                state_d = ACCESS;
                win_d   = pick;
                last_d  = pick;
                we_d    = pick ? we1_i : we0_i;
                addr_d  = pick ? addr1_i : addr0_i;
                din_d   = pick ? wdata1_i : wdata0_i;
                cnt_d   = (pick & lock1_i) ? ((cnt_q < CW'(MAX_LOCK)) ? cnt_q + CW'(1) : cnt_q) : '0;
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = we_q ? rdata_q : mem_dout_i;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end
    assign gnt0_o     = (state_q == ACCESS) & ~win_q;
    assign gnt1_o     = (state_q == ACCESS) & win_q;
    assign done0_o    = (state_q == RESP) & ~win_q;
    assign done1_o    = (state_q == RESP) & win_q;
    assign mem_we_o   = (state_q == ACCESS) & we_q;
    assign busy_o     = state_q != IDLE;
    assign mem_addr_o = addr_q;
    assign mem_din_o  = din_q;
    assign rdata_o    = rdata_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural memory.
module tb_dm_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0, lock1 = 0;
    logic [9:0]  addr0 = 0, addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, done0, done1, mem_we, busy;
    logic [31:0] rdata, mem_din, mem_dout;
    logic [9:0]  mem_addr;
    logic [31:0] mem [1024];
    int          errs = 0, checks = 0;
    logic [31:0] last_r = 0;

    typedef struct packed {
        logic        p;
        logic        w;
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] r;
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    dm_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .gnt0_o(gnt0), .done0_o(done0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .lock1_i(lock1), .gnt1_o(gnt1), .done1_o(done1),
        .rdata_o(rdata), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
        .mem_we_o(mem_we), .mem_dout_i(mem_dout), .busy_o(busy)
    );

    always #5 clk = ~clk;
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on every grant, checks its completion.
    always @(negedge clk) if (rst_n) begin
        if (gnt0 | gnt1) begin
            if (sb.size() == 0) check("unexpected_gnt", 1, 0);
            else begin
                cur = sb.pop_front();
                check("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
                check("gnt_port", {31'd0, gnt1}, {31'd0, cur.p});
                check("acc_we", {31'd0, mem_we}, {31'd0, cur.w});
                check("acc_addr", {22'd0, mem_addr}, {22'd0, cur.a});
                if (cur.w) check("acc_din", mem_din, cur.d);
            end
        end
        if (done0 | done1) begin
            check("done_excl", {31'd0, done0 & done1}, 0);
            check("done_port", {31'd0, done1}, {31'd0, cur.p});
            check("rdata", rdata, cur.r);
            check("resp_we", {31'd0, mem_we}, 0);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; lock1 = 0;
        last_r = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic access(input logic p, input logic w, input logic [9:0] a,
                          input logic [31:0] d, input logic [31:0] r);
        int n;
        sb.push_back('{p, w, a, d, w ? last_r : r});
        if (!w) last_r = r;
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(p ? gnt1 : gnt0) && n < 20);
        check("gnt_lat", n, 1);
        req0 = 0; req1 = 0;
        we0 = ~we0; we1 = ~we1; addr0 = ~addr0; addr1 = ~addr1; wdata0 = ~wdata0; wdata1 = ~wdata1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(p ? done1 : done0) && n < 20);
        check("done_lat", n, 1);
        @(negedge clk);
    endtask

    task automatic contend(input logic lk, input int n, input logic [7:0] seq);
        int k, cyc, lastc;
        for (int i = 0; i < n; i++)
            sb.push_back('{seq[i], 1'b0, seq[i] ? 10'h020 : 10'h010, 32'd0,
                           seq[i] ? 32'hA000_0020 : 32'hA000_0010});
        we0 = 0; we1 = 0; addr0 = 10'h010; addr1 = 10'h020; lock1 = lk;
        req0 = 1; req1 = 1;
        k = 0; cyc = 0; lastc = 0;
        while (k < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (gnt0 | gnt1) begin
                if (k > 0) check("grant_gap", cyc - lastc, 3);
                lastc = cyc;
                k++;
            end
        end
        req0 = 0; req1 = 0; lock1 = 0;
        check("grant_count", k, n);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[5] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 0);
        check("rst_addr", {22'd0, mem_addr}, 0);
        check("rst_din", mem_din, 0);
        check("rst_ctrl", {26'd0, mem_we, busy, gnt0, gnt1, done0, done1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        access(0, 0, 10'h005, 32'h0, 32'h1234_5678);
        access(1, 1, 10'h3FF, 32'hDEAD_BEEF, 32'h0);
        check("mem_3ff", mem[10'h3FF], 32'hDEAD_BEEF);
        access(0, 1, 10'h055, 32'hA5A5_5A5A, 32'h0);
        access(1, 0, 10'h055, 32'h0, 32'hA5A5_5A5A);
        access(0, 0, 10'h3FF, 32'h0, 32'hDEAD_BEEF);

        // A request pulse that never sees a rising edge must not be granted.
        #1 req0 = 1; #2 req0 = 0;
        n = 0;
        repeat (5) begin @(negedge clk); if (gnt0 | gnt1 | done0 | done1) n++; end
        check("pulse_ignored", n, 0);

        do_reset();
        contend(0, 4, 8'b0000_1010);
        do_reset();
        contend(1, 6, 8'b0001_1110);

        do_reset();
        sb.push_back('{1'b1, 1'b1, 10'h077, 32'hCAFE_F00D, 32'h0});
        req1 = 1; we1 = 1; addr1 = 10'h077; wdata1 = 32'hCAFE_F00D;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt1 && n < 20);
        check("abort_gnt", {31'd0, mem_we}, 1);
        #2 rst_n = 1'b0;
        #1 check("abort_we", {29'd0, mem_we, busy, gnt1}, 0);
        req1 = 0;
        n = 0;
        repeat (3) begin @(negedge clk); if (done0 | done1) n++; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); if (done0 | done1) n++; end
        check("abort_no_done", n, 0);
        check("abort_mem", mem[10'h077], 32'hA000_0077);
        contend(0, 2, 8'b0000_0010);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
